// File: rtl/ram_ai_sequencer.sv
// ram_ai_sequencer
//   Owns the single port of the alpha-coefficient RAM (registered read,
//   1-cycle latency) and shares it between a host byte-load stream and
//   the classifier's full read sweep with valid/ready backpressure.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_valid/data/last       host byte stream in
//   load_ready                 host byte accepted this cycle
//   sweep_start                single-cycle request for a full read sweep
//   busy                       FSM not in IDLE
//   ram_address/we/qin         RAM port drive
//   ram_data_out               RAM read data
//   out_valid/data/index/last  coefficient word stream out
//   out_ready                  consumer accepts the word
//   sweep_done                 one-cycle pulse after the last word is taken
//   load_overflow              sticky: a byte was offered past NUM_SV-1
//   checksum                   sweep sum of accepted words
//
// Build option
//   SWEEP_CHECKSUM_EN  defined: checksum accumulates accepted words
//                      undefined: checksum tied to 0, no accumulator
module ram_ai_sequencer #(
  parameter int NUM_SV = 629,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LOAD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              sweep_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  output logic [LOAD_W-1:0] ram_qin,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sweep_done,
  output logic              load_overflow,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRIME = 3'd2,
    SWEEP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SV - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              ovf_nxt;
  // Set when a load filled the RAM without load_last; while the host keeps
  // offering bytes they are flagged as overflow instead of starting a new load.
  logic              ovf_pend, ovf_pend_nxt;

  assign out_data = ram_data_out;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idx_nxt      = idx;
    ovf_nxt      = load_overflow;
    ovf_pend_nxt = ovf_pend;
    load_ready   = 1'b0;
    busy         = (state != IDLE);
    ram_we       = 1'b0;
    ram_address  = '0;
    ram_qin      = '0;
    out_valid    = 1'b0;
    out_index    = '0;
    out_last     = 1'b0;
    sweep_done   = 1'b0;

    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt    = PRIME;
          ovf_pend_nxt = 1'b0;
        end else if (load_valid) begin
          if (ovf_pend) begin
            ovf_nxt = 1'b1;
          end else begin
            state_nxt = LOAD;
            ptr_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end else begin
          ovf_pend_nxt = 1'b0;
        end
      end

      LOAD: begin
        load_ready  = (ptr <= LAST_ADDR);
        ram_address = ptr;
        if (load_valid && load_ready) begin
          ram_we  = 1'b1;
          ram_qin = load_data;
          if (load_last || (ptr == LAST_ADDR)) begin
            state_nxt    = IDLE;
            ovf_pend_nxt = !load_last;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end

      PRIME: begin
        ram_address = '0;
        state_nxt   = SWEEP;
        idx_nxt     = '0;
      end

      SWEEP: begin
        out_valid = 1'b1;
        out_index = idx;
        out_last  = (idx == LAST_ADDR);
        // Address runs one ahead on accept so the next word arrives in time;
        // on stall it re-reads the current word.
        ram_address = out_ready ? idx + 1'b1 : idx;
        if (out_ready) begin
          if (idx == LAST_ADDR) state_nxt = DONE;
          else                  idx_nxt   = idx + 1'b1;
        end
      end

      DONE: begin
        sweep_done = 1'b1;
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      idx           <= '0;
      load_overflow <= 1'b0;
      ovf_pend      <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      idx           <= idx_nxt;
      load_overflow <= ovf_nxt;
      ovf_pend      <= ovf_pend_nxt;
    end
  end

`ifdef SWEEP_CHECKSUM_EN
  logic              ck_clr, ck_acc;
  logic [DATA_W-1:0] ck;

  assign ck_clr   = (state == IDLE) && sweep_start;
  assign ck_acc   = (state == SWEEP) && out_ready;
  assign checksum = ck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ck <= '0;
    else if (ck_clr) ck <= '0;
    else if (ck_acc) ck <= ck + ram_data_out;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_ai_sequencer.sv
module tb_ram_ai_sequencer;

  localparam int NUM_SV = 629;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LOAD_W = 8;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic [LOAD_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              sweep_start;
  logic              busy;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_we;
  logic [LOAD_W-1:0] ram_qin;
  logic [DATA_W-1:0] ram_data_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              out_ready;
  logic              sweep_done;
  logic              load_overflow;
  logic [DATA_W-1:0] checksum;

  ram_ai_sequencer #(
    .NUM_SV(NUM_SV),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LOAD_W(LOAD_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .sweep_start  (sweep_start),
    .busy         (busy),
    .ram_address  (ram_address),
    .ram_we       (ram_we),
    .ram_qin      (ram_qin),
    .ram_data_out (ram_data_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .sweep_done   (sweep_done),
    .load_overflow(load_overflow),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient RAM: registered read, write on we, preloaded with a[i]=i.
  logic [DATA_W-1:0] ram [NUM_SV];
  logic              preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NUM_SV; i++) ram[i] <= DATA_W'(i);
    end else if (ram_we && (int'(ram_address) < NUM_SV)) begin
      ram[ram_address] <= DATA_W'(ram_qin);
    end
    ram_data_out <= (int'(ram_address) < NUM_SV) ? ram[ram_address] : '0;
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } item_t;

  item_t             sq[$];
  item_t             wq[$];
  logic [DATA_W-1:0] ref_mem [NUM_SV];
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return 1ns after the rise.
  task automatic step();
    item_t e;
    @(negedge clk);
    if (ram_we) begin
      check("we_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("we_addr", 64'(ram_address), 64'(e.addr));
        check("we_data", 64'(ram_qin), 64'(e.data));
      end
    end
    if (out_valid && out_ready) begin
      check("word_expected", 64'(sq.size() != 0), 64'd1);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        check("word_index", 64'(out_index), 64'(e.addr));
        check("word_data", 64'(out_data), 64'(e.data));
        check("word_last", 64'(out_last), 64'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({load_ready, busy, ram_we, ram_address, ram_qin, out_valid,
                    out_index, out_last, sweep_done, load_overflow}), 64'd0);
    check({tag, "_ck"}, 64'(checksum), 64'd0);
  endtask

  task automatic run_sweep(input int stall_at, input int stall_len, input int reset_at);
    int                edges;
    int                stalls;
    int                exp_edges;
    bit                done;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] exp_ck;
    sum = '0;
    for (int i = 0; i < NUM_SV; i++) begin
      sq.push_back('{ADDR_W'(i), ref_mem[i], (i == NUM_SV - 1)});
      sum = sum + ref_mem[i];
    end
`ifdef SWEEP_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif
    exp_edges = NUM_SV + 2 + ((stall_at >= 0) ? stall_len : 0);
    out_ready   = 1'b1;
    sweep_start = 1'b1;
    step();
    edges       = 1;
    sweep_start = 1'b0;
    check("prime_busy", 64'(busy), 64'd1);
    check("prime_no_valid", 64'(out_valid), 64'd0);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < NUM_SV + 50 && !done; c++) begin
      if (edges == 2) begin
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_index", 64'(out_index), 64'd0);
      end
      if (reset_at >= 0 && out_valid && int'(out_index) == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_sweep");
        sq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (stall_at >= 0 && out_valid && int'(out_index) == stall_at && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        #1;
        check("stall_index", 64'(out_index), 64'(stall_at));
        check("stall_addr", 64'(ram_address), 64'(stall_at));
        check("stall_data", 64'(out_data), 64'(ref_mem[stall_at]));
      end else begin
        out_ready = 1'b1;
      end
      step();
      edges++;
      if (sweep_done) done = 1'b1;
    end
    check("sweep_done_seen", 64'(done), 64'd1);
    if (done) begin
      check("done_cycle", 64'(edges), 64'(exp_edges));
      check("done_no_valid", 64'(out_valid), 64'd0);
      check("sweep_sb_empty", 64'(sq.size()), 64'd0);
      check("checksum", 64'(checksum), 64'(exp_ck));
      step();
      check("done_one_cycle", 64'(sweep_done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
      check("checksum_hold", 64'(checksum), 64'(exp_ck));
    end
  endtask

  task automatic load_bytes(input int n, input logic [7:0] base, input logic [7:0] stride,
                            input bit with_last);
    bit acc;
    for (int k = 0; k < n; k++) begin
      load_valid = 1'b1;
      load_data  = LOAD_W'(base + 8'(k) * stride);
      load_last  = with_last && (k == n - 1);
      if (k < NUM_SV) begin
        wq.push_back('{ADDR_W'(k), DATA_W'(load_data), 1'b0});
        ref_mem[k] = DATA_W'(load_data);
      end
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) begin
        acc = load_ready;
        step();
      end
      if (k < NUM_SV) check("load_accept", 64'(acc), 64'd1);
      else            check("load_reject", 64'(acc), 64'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    bit acc;
    rst_n       = 1'b0;
    preload     = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    sweep_start = 1'b0;
    out_ready   = 1'b0;
    for (int i = 0; i < NUM_SV; i++) ref_mem[i] = DATA_W'(i);
    @(posedge clk);
    @(posedge clk);
    #1;
    preload = 1'b0;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // Full sweep with out_ready held high.
    run_sweep(-1, 0, -1);

    // Three-cycle consumer stall at index 5.
    run_sweep(5, 3, -1);

    // Short load terminated by load_last.
    load_bytes(4, 8'h11, 8'h11, 1'b1);
    check("load4_idle", 64'(busy), 64'd0);
    check("load4_no_ovf", 64'(load_overflow), 64'd0);
    check("load4_sb_empty", 64'(wq.size()), 64'd0);

    // sweep_start and load_valid together: sweep wins, load follows.
    load_valid = 1'b1;
    load_data  = 8'hAA;
    load_last  = 1'b1;
    run_sweep(-1, 0, -1);
    wq.push_back('{ADDR_W'(0), DATA_W'(8'hAA), 1'b0});
    ref_mem[0] = DATA_W'(8'hAA);
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) begin
      acc = load_ready;
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("deferred_load_accept", 64'(acc), 64'd1);
    check("deferred_load_sb_empty", 64'(wq.size()), 64'd0);
    check("deferred_load_idle", 64'(busy), 64'd0);

    // 630 bytes without load_last: 629 writes then overflow.
    load_bytes(NUM_SV + 1, 8'h05, 8'h07, 1'b0);
    check("overflow_set", 64'(load_overflow), 64'd1);
    check("overflow_sb_empty", 64'(wq.size()), 64'd0);
    step();
    check("overflow_sticky", 64'(load_overflow), 64'd1);
    check("overflow_idle", 64'(busy), 64'd0);

    // Reset at index 100, then a fresh sweep from index 0.
    run_sweep(-1, 0, 100);
    check("post_reset_ovf", 64'(load_overflow), 64'd0);
    run_sweep(-1, 0, -1);

    check("final_sq_empty", 64'(sq.size()), 64'd0);
    check("final_wq_empty", 64'(wq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
